bp_cache_req_arbiter: RTL and testbench
=======================================

// Module: bp_cache_req_arbiter
// PURPOSE
//  Shares one LCE cache-request port between two cache requesters (0 = I$, 1 = D$).
//  Runs one miss transaction at a time: request, then metadata, then completion.
//  Round-robin grant; the LCE's completion is routed back to the owning cache.
//  Sits between the FE/BE cache engines and the single LCE request interface in the tile.
// PARAMETERS
//  req_width_p   64  width of the packed cache_req struct (set from cache_req_width_lp)
//  meta_width_p  8   width of the packed metadata struct (set from cache_req_metadata_width_lp)
// PORTS
//  clk_i                   in   1             clock
//  reset_n_i               in   1             asynchronous, active-low reset
//  req0_i / req1_i         in   req_width_p   cache request from requester 0 / 1
//  req0_v_i / req1_v_i     in   1             request valid
//  req0_ready_o/req1_ready_o out 1            request accepted this cycle (valid&ready handshake)
//  meta0_i / meta1_i       in   meta_width_p  request metadata
//  meta0_v_i / meta1_v_i   in   1             metadata valid
//  complete0_o/complete1_o out  1             one-cycle completion pulse to the owner
//  cache_req_o             out  req_width_p   request to LCE
//  cache_req_v_o           out  1             request valid to LCE
//  cache_req_ready_i       in   1             LCE can accept the request
//  cache_req_metadata_o    out  meta_width_p  metadata to LCE
//  cache_req_metadata_v_o  out  1             metadata valid to LCE
//  cache_req_complete_i    in   1             LCE reports the transaction done
//  owner_o                 out  1             requester id of the current/last transaction
//  busy_o                  out  1             a transaction is in flight
//  error_o                 out  1             sticky protocol-violation flag
// BEHAVIOUR
//  Reset (async assert, deasserted synchronously to clk_i):
//   - state=IDLE; owner_o=0; last_grant=1, so requester 0 wins the first tie.
//   - All outputs are 0: every valid, ready and complete signal, busy_o, error_o and both data buses.
//  IDLE:
//   - Select one requester combinationally: the only valid one, or on a tie the one != last_grant.
//   - cache_req_o = selected req; cache_req_v_o = 1 if any requester is valid.
//   - reqN_ready_o = cache_req_ready_i & (N selected); the non-selected requester sees ready=0.
//   - On handshake: register owner, go to META. Latency 0 (combinational forward).
//  META:
//   - cache_req_v_o = 0.
//   - cache_req_metadata_o = meta of owner; cache_req_metadata_v_o = metaN_v_i of owner.
//   - When owner meta_v is seen, go to BUSY. Non-owner meta_v is ignored and sets error_o.
//   - Metadata is required at least 1 cycle after request acceptance; meta_v in the accept cycle sets error_o.
//  BUSY:
//   - Wait for cache_req_complete_i. On arrival, completeN_o=1 for the owner in the same cycle
//     (combinational), last_grant<=owner, go to IDLE.
//   - New grants can be issued from the next cycle.
//  busy_o = (state != IDLE). owner_o holds its value after the transaction completes.
//  error_o (sticky until reset) is set by:
//   - cache_req_complete_i in IDLE or META;
//   - meta_v from either requester in IDLE.
//  Once error_o is set, the FSM continues normally; errors are never fatal to the sequence.
//  Requests held valid while not granted must remain stable; the arbiter never drops one.
//  Fairness: with both requesters valid continuously, grants strictly alternate 0,1,0,1...
//  Reset mid-transaction: return to IDLE immediately; no completion pulse is produced.
// TESTING
//  1. Only req0 valid, ready=1 -> grant 0 in cycle 0; meta at +1 forwarded; complete at +5 -> complete0_o pulse, busy_o falls.
//  2. Both valid back-to-back, ready=1, complete 3 cycles after meta -> grant order 0,1,0,1; never two in flight.
//  3. req1 valid, cache_req_ready_i=0 for 4 cycles -> req1_ready_o=0 and state stays IDLE; accepted in cycle 5.
//  4. complete_i pulsed in IDLE -> error_o=1 and remains set; a subsequent normal transaction still completes.
//  5. Reset asserted in BUSY -> all outputs 0 asynchronously; after release, req0 wins the tie against req1.
//  6. Non-owner meta_v during META -> ignored, owner metadata still forwarded, error_o=1.

Source files
------------

// File: rtl/bp_cache_req_arbiter.sv
// Two-way round-robin arbiter sharing one LCE cache-request port between I$ (0) and D$ (1).
// One miss transaction in flight at a time: request, metadata, then completion.
module bp_cache_req_arbiter #(
    parameter int unsigned req_width_p  = 64,
    parameter int unsigned meta_width_p = 8
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,

    input  logic [req_width_p-1:0]  req0_i,
    input  logic                    req0_v_i,
    output logic                    req0_ready_o,
    input  logic [req_width_p-1:0]  req1_i,
    input  logic                    req1_v_i,
    output logic                    req1_ready_o,

    input  logic [meta_width_p-1:0] meta0_i,
    input  logic                    meta0_v_i,
    input  logic [meta_width_p-1:0] meta1_i,
    input  logic                    meta1_v_i,

    output logic                    complete0_o,
    output logic                    complete1_o,

    output logic [req_width_p-1:0]  cache_req_o,
    output logic                    cache_req_v_o,
    input  logic                    cache_req_ready_i,
    output logic [meta_width_p-1:0] cache_req_metadata_o,
    output logic                    cache_req_metadata_v_o,
    input  logic                    cache_req_complete_i,

    output logic                    owner_o,
    output logic                    busy_o,
    output logic                    error_o
);

    typedef enum logic [1:0] {StIdle, StMeta, StBusy} state_e;

    state_e state_q, state_d;
    logic   owner_q, owner_d;
    logic   last_grant_q, last_grant_d;
    logic   error_q, error_d;

    logic any_v;
    logic sel;
    logic owner_meta_v;
    logic other_meta_v;

    always_comb begin
        any_v        = req0_v_i | req1_v_i;
        // On a tie the requester that did not win last time gets the grant.
        sel          = (req0_v_i & req1_v_i) ? ~last_grant_q : req1_v_i;
        owner_meta_v = owner_q ? meta1_v_i : meta0_v_i;
        other_meta_v = owner_q ? meta0_v_i : meta1_v_i;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q      <= StIdle;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            error_q      <= error_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        error_d      = error_q;
        case (state_q)
            StIdle: begin
                if (any_v && cache_req_ready_i) begin
                    state_d = StMeta;
                    owner_d = sel;
                end
                // Metadata must trail acceptance by a cycle, so any meta_v here is a violation.
                if (cache_req_complete_i || meta0_v_i || meta1_v_i) begin
                    error_d = 1'b1;
                end
            end
            StMeta: begin
                if (owner_meta_v) begin
                    state_d = StBusy;
                end
                if (other_meta_v || cache_req_complete_i) begin
                    error_d = 1'b1;
                end
            end
            StBusy: begin
                if (cache_req_complete_i) begin
                    state_d      = StIdle;
                    last_grant_d = owner_q;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        cache_req_o            = '0;
        cache_req_v_o          = 1'b0;
        req0_ready_o           = 1'b0;
        req1_ready_o           = 1'b0;
        cache_req_metadata_o   = '0;
        cache_req_metadata_v_o = 1'b0;
        complete0_o            = 1'b0;
        complete1_o            = 1'b0;
        case (state_q)
            StIdle: begin
                // The IDLE path is combinational from inputs; hold it quiet while in reset.
                if (reset_n_i && any_v) begin
                    cache_req_v_o = 1'b1;
                    cache_req_o   = sel ? req1_i : req0_i;
                    req0_ready_o  = cache_req_ready_i & ~sel;
                    req1_ready_o  = cache_req_ready_i & sel;
                end
            end
            StMeta: begin
                cache_req_metadata_o   = owner_q ? meta1_i : meta0_i;
                cache_req_metadata_v_o = owner_meta_v;
            end
            StBusy: begin
                complete0_o = cache_req_complete_i & ~owner_q;
                complete1_o = cache_req_complete_i & owner_q;
            end
            default: ;
        endcase
    end

    assign owner_o = owner_q;
    assign busy_o  = (state_q != StIdle);
    assign error_o = error_q;

endmodule

// File: tb/tb_bp_cache_req_arbiter.sv
// Directed, table-driven bench for bp_cache_req_arbiter; one table row per clock cycle,
// plus a hand-written sequence for reset asserted mid-transaction.
module tb_bp_cache_req_arbiter;

    localparam logic [63:0] R0 = 64'h0000_0000_AAAA_0000;
    localparam logic [63:0] R1 = 64'h1111_BBBB_0000_0001;
    localparam logic [7:0]  M0 = 8'h5A;
    localparam logic [7:0]  M1 = 8'hC3;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [63:0] req0, req1;
    logic        req0_v, req1_v, req0_ready, req1_ready;
    logic [7:0]  meta0, meta1;
    logic        meta0_v, meta1_v;
    logic        complete0, complete1;
    logic [63:0] cache_req;
    logic        cache_req_v, cache_req_ready;
    logic [7:0]  cache_req_metadata;
    logic        cache_req_metadata_v, cache_req_complete;
    logic        owner, busy, error;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    bp_cache_req_arbiter #(.req_width_p(64), .meta_width_p(8)) dut (
        .clk_i                  (clk),
        .reset_n_i              (reset_n),
        .req0_i                 (req0),
        .req0_v_i               (req0_v),
        .req0_ready_o           (req0_ready),
        .req1_i                 (req1),
        .req1_v_i               (req1_v),
        .req1_ready_o           (req1_ready),
        .meta0_i                (meta0),
        .meta0_v_i              (meta0_v),
        .meta1_i                (meta1),
        .meta1_v_i              (meta1_v),
        .complete0_o            (complete0),
        .complete1_o            (complete1),
        .cache_req_o            (cache_req),
        .cache_req_v_o          (cache_req_v),
        .cache_req_ready_i      (cache_req_ready),
        .cache_req_metadata_o   (cache_req_metadata),
        .cache_req_metadata_v_o (cache_req_metadata_v),
        .cache_req_complete_i   (cache_req_complete),
        .owner_o                (owner),
        .busy_o                 (busy),
        .error_o                (error)
    );

    // rs/ms select the expected bus value: 0 -> zero, 1 -> requester 0, 2 -> requester 1.
    typedef struct {
        string tag;
        bit    rst;
        bit    v0, v1, m0v, m1v, rdy, cpl;
        bit    cv;
        int    rs;
        bit    r0, r1, mv;
        int    ms;
        bit    c0, c1, bsy, own, err;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input string tag, input bit rst,
                       input bit v0, input bit v1, input bit m0v, input bit m1v,
                       input bit rdy, input bit cpl,
                       input bit cv, input int rs, input bit r0, input bit r1,
                       input bit mv, input int ms, input bit c0, input bit c1,
                       input bit bsy, input bit own, input bit err);
        vec_t v;
        v.tag = tag; v.rst = rst;
        v.v0 = v0; v.v1 = v1; v.m0v = m0v; v.m1v = m1v; v.rdy = rdy; v.cpl = cpl;
        v.cv = cv; v.rs = rs; v.r0 = r0; v.r1 = r1; v.mv = mv; v.ms = ms;
        v.c0 = c0; v.c1 = c1; v.bsy = bsy; v.own = own; v.err = err;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input bit v0, input bit v1, input bit m0v, input bit m1v,
                         input bit rdy, input bit cpl);
        req0_v = v0; req1_v = v1; meta0_v = m0v; meta1_v = m1v;
        cache_req_ready = rdy; cache_req_complete = cpl;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    function automatic logic [63:0] req_val(input int s);
        return (s == 1) ? R0 : (s == 2) ? R1 : 64'd0;
    endfunction

    function automatic logic [63:0] meta_val(input int s);
        return (s == 1) ? {56'd0, M0} : (s == 2) ? {56'd0, M1} : 64'd0;
    endfunction

    task automatic chk_all_zero(input string p);
        chk({p, "_req_v"},  {63'd0, cache_req_v}, 64'd0);
        chk({p, "_req"},    cache_req, 64'd0);
        chk({p, "_rdy"},    {62'd0, req1_ready, req0_ready}, 64'd0);
        chk({p, "_meta"},   {55'd0, cache_req_metadata_v, cache_req_metadata}, 64'd0);
        chk({p, "_cpl"},    {62'd0, complete1, complete0}, 64'd0);
        chk({p, "_status"}, {61'd0, owner, busy, error}, 64'd0);
    endtask

    initial begin
        reset_n = 1'b1;
        req0 = R0; req1 = R1; meta0 = M0; meta1 = M1;
        drive(0, 0, 0, 0, 0, 0);

        // Only req0, grant at cycle 0, meta at +1, complete at +5.
        //  tag             rst v0 v1 m0 m1 rdy cpl | cv rs r0 r1 mv ms c0 c1 bsy own err
        add("t1_grant",     1, 1, 0, 0, 0, 1, 0,   1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        add("t1_meta",      0, 0, 0, 1, 0, 1, 0,   0, 0, 0, 0, 1, 1, 0, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++)
            add("t1_wait",  0, 0, 0, 0, 0, 1, 0,   0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        add("t1_cpl",       0, 0, 0, 0, 0, 1, 1,   0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0);
        add("t1_idle",      0, 0, 0, 0, 0, 1, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // req1 stalled by LCE for 4 cycles, accepted on the 5th.
        for (int i = 0; i < 4; i++)
            add("t3_stall", 0, 0, 1, 0, 0, 0, 0,   1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add("t3_acc",       0, 0, 1, 0, 0, 1, 0,   1, 2, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        add("t3_meta",      0, 0, 0, 0, 1, 0, 0,   0, 0, 0, 0, 1, 2, 0, 0, 1, 1, 0);
        add("t3_cpl",       0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0);
        // Both valid continuously: grants alternate 0,1,0,1; nothing accepted while busy.
        for (int k = 0; k < 4; k++) begin
            bit o;
            o = k[0];
            add("t2_grant", 0, 1, 1, 0, 0, 1, 0,   1, o ? 2 : 1, !o, o, 0, 0, 0, 0, 0, !o, 0);
            add("t2_meta",  0, 1, 1, !o, o, 1, 0,  0, 0, 0, 0, 1, o ? 2 : 1, 0, 0, 1, o, 0);
            for (int i = 0; i < 2; i++)
                add("t2_wait", 0, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, o, 0);
            add("t2_cpl",   0, 1, 1, 0, 0, 1, 1,   0, 0, 0, 0, 0, 0, !o, o, 1, o, 0);
        end
        // Stray completion in IDLE: sticky error, later transaction still completes.
        add("t4_badcpl",    0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        add("t4_sticky",    0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        add("t4_grant",     0, 1, 0, 0, 0, 1, 0,   1, 1, 1, 0, 0, 0, 0, 0, 0, 1, 1);
        add("t4_meta",      0, 0, 0, 1, 0, 0, 0,   0, 0, 0, 0, 1, 1, 0, 0, 1, 0, 1);
        add("t4_cpl",       0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 1);
        add("t4_idle",      0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        // Non-owner metadata during META is ignored but flagged.
        add("t6_grant",     1, 1, 0, 0, 0, 1, 0,   1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        add("t6_other",     0, 0, 0, 0, 1, 0, 0,   0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0);
        add("t6_owner",     0, 0, 0, 1, 1, 0, 0,   0, 0, 0, 0, 1, 1, 0, 0, 1, 0, 1);
        add("t6_cpl",       0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 1);
        // Metadata in the accept cycle is a violation; transaction still proceeds.
        add("t7_grant",     1, 1, 0, 1, 0, 1, 0,   1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        add("t7_meta",      0, 0, 0, 1, 0, 0, 0,   0, 0, 0, 0, 1, 1, 0, 0, 1, 0, 1);
        add("t7_cpl",       0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 1);

        // Reset state with both requesters valid: everything must read 0.
        @(negedge clk);
        reset_n = 1'b0;
        drive(1, 1, 1, 1, 1, 1);
        #1;
        chk_all_zero("rst_state");
        do_reset();

        foreach (vecs[i]) begin
            vec_t v;
            string p;
            v = vecs[i];
            p = $sformatf("%s[%0d]", v.tag, i);
            if (v.rst) do_reset();
            @(negedge clk);
            drive(v.v0, v.v1, v.m0v, v.m1v, v.rdy, v.cpl);
            #1;
            chk({p, "_req_v"}, {63'd0, cache_req_v}, {63'd0, v.cv});
            chk({p, "_req"},   cache_req, req_val(v.rs));
            chk({p, "_rdy0"},  {63'd0, req0_ready}, {63'd0, v.r0});
            chk({p, "_rdy1"},  {63'd0, req1_ready}, {63'd0, v.r1});
            chk({p, "_mv"},    {63'd0, cache_req_metadata_v}, {63'd0, v.mv});
            chk({p, "_meta"},  {56'd0, cache_req_metadata}, meta_val(v.ms));
            chk({p, "_cpl0"},  {63'd0, complete0}, {63'd0, v.c0});
            chk({p, "_cpl1"},  {63'd0, complete1}, {63'd0, v.c1});
            chk({p, "_busy"},  {63'd0, busy}, {63'd0, v.bsy});
            chk({p, "_owner"}, {63'd0, owner}, {63'd0, v.own});
            chk({p, "_err"},   {63'd0, error}, {63'd0, v.err});
        end

        // Reset asserted in BUSY (owner 1): outputs clear at once, no completion pulse,
        // and req0 wins the first tie after release.
        do_reset();
        @(negedge clk);
        drive(0, 1, 0, 0, 1, 0);
        @(negedge clk);
        drive(0, 0, 0, 1, 0, 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        #1;
        chk("t5_busy",  {63'd0, busy}, 64'd1);
        chk("t5_owner", {63'd0, owner}, 64'd1);
        #2;
        drive(1, 1, 1, 0, 1, 1);
        reset_n = 1'b0;
        #1;
        chk_all_zero("t5_async");
        @(posedge clk);
        #1;
        chk_all_zero("t5_held");
        @(negedge clk);
        drive(1, 1, 0, 0, 1, 0);
        reset_n = 1'b1;
        #1;
        chk("t5_rel_req",  cache_req, R0);
        chk("t5_rel_rdy",  {62'd0, req1_ready, req0_ready}, 64'd1);
        chk("t5_rel_stat", {61'd0, owner, busy, error}, 64'd0);
        @(posedge clk);
        #1;
        chk("t5_owner0",   {61'd0, owner, busy, error}, 64'd2);
        drive(0, 0, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
